// File: rtl/dac_pkg.sv
// dac_pkg: shared types and default widths for the DAC pattern generator
package dac_pkg;
  localparam int BITS_DEF = 4;
  localparam int DIV_W_DEF = 16;
  typedef enum logic [1:0] {MODE_RAMP_UP, MODE_RAMP_DOWN, MODE_TRIANGLE, MODE_HOLD} mode_t;
  typedef enum logic [1:0] {ST_IDLE, ST_UP, ST_DOWN, ST_HOLD} state_t;
endpackage

// File: rtl/dac_tick_div.sv
// dac_tick_div: step prescaler, counts 0..div and flags the wrap cycle as a tick
//   clk/rst : clock, sync active-high reset
//   clr     : force the count back to 0 (idle and run entry)
//   div     : step period minus 1
//   tick    : high in the cycle the count equals div
module dac_tick_div
  import dac_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);
  logic [DIV_W-1:0] cnt_q;
  assign tick = cnt_q == div;
  always_ff @(posedge clk) begin
    if (rst || clr || tick) cnt_q <= '0;
    else cnt_q <= cnt_q + 1'b1;
  end
endmodule

// File: rtl/dac_pattern_gen.sv
// dac_pattern_gen: ramp/triangle/hold code sweeps for a resistor-ladder DAC
//   cfg_valid/cfg_ready : config handshake, accepted only in IDLE
//   cfg_mode/div/level  : sweep mode, step period minus 1, hold code
//   enable              : run request level
//   dac_code            : registered code word
//   dac_strobe          : pulse with every new step value
//   sweep_start         : pulse at the start of each sweep
//   busy                : not idle
module dac_pattern_gen
  import dac_pkg::*;
#(
  parameter int BITS  = BITS_DEF,
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [1:0]       cfg_mode,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [BITS-1:0]  cfg_level,
  input  logic             enable,
  output logic [BITS-1:0]  dac_code,
  output logic             dac_strobe,
  output logic             sweep_start,
  output logic             busy
);
  localparam logic [BITS-1:0] MAX = '1;
  state_t           state_q, state_d;
  mode_t            mode_q, mode_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [BITS-1:0]  level_q, level_d, code_q, start_d;
  logic             strobe_q, sweep_q, tick, hs;
  assign cfg_ready   = state_q == ST_IDLE;
  assign busy        = !cfg_ready;
  assign dac_code    = code_q;
  assign dac_strobe  = strobe_q;
  assign sweep_start = sweep_q;
  assign hs          = cfg_valid && cfg_ready;
  // A config accepted in the entry cycle applies to that very sweep.
  always_comb begin
    mode_d  = hs ? mode_t'(cfg_mode) : mode_q;
    div_d   = hs ? cfg_div : div_q;
    level_d = hs ? cfg_level : level_q;
    state_d = mode_d == MODE_RAMP_DOWN ? ST_DOWN : mode_d == MODE_HOLD ? ST_HOLD : ST_UP;
    start_d = mode_d == MODE_RAMP_DOWN ? MAX : mode_d == MODE_HOLD ? level_d : '0;
  end
  // The prescaler sits at 0 in idle and restarts whenever a run is entered or aborted.
  dac_tick_div #(.DIV_W(DIV_W)) u_div (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_q == ST_IDLE || !enable),
    .div  (div_q),
    .tick (tick)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      mode_q   <= MODE_RAMP_UP;
      div_q    <= '0;
      level_q  <= '0;
      code_q   <= '0;
      strobe_q <= 1'b0;
      sweep_q  <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      sweep_q  <= 1'b0;
      if (state_q == ST_IDLE) begin
        mode_q  <= mode_d;
        div_q   <= div_d;
        level_q <= level_d;
        code_q  <= '0;
        if (enable) begin
          state_q  <= state_d;
          code_q   <= start_d;
          strobe_q <= 1'b1;
          sweep_q  <= 1'b1;
        end
      end else if (!enable) begin
        state_q <= ST_IDLE;
        code_q  <= '0;
      end else if (tick) begin
        strobe_q <= 1'b1;
        case (state_q)
          ST_UP:
            if (code_q != MAX) code_q <= code_q + 1'b1;
            else if (mode_q == MODE_TRIANGLE) begin
              state_q <= ST_DOWN;
              code_q  <= MAX - 1'b1;
            end else begin
              code_q  <= '0;
              sweep_q <= 1'b1;
            end
          ST_DOWN:
            if (code_q != '0) code_q <= code_q - 1'b1;
            else if (mode_q == MODE_TRIANGLE) begin
              state_q <= ST_UP;
              code_q  <= 1;
              sweep_q <= 1'b1;
            end else begin
              code_q  <= MAX;
              sweep_q <= 1'b1;
            end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_dac_pattern_gen.sv
// tb_dac_pattern_gen: scoreboard bench for dac_pattern_gen against a step-index reference model
module tb_dac_pattern_gen;
  logic        clk = 1'b0;
  logic        rst, cfg_valid, enable;
  logic [1:0]  cfg_mode;
  logic [15:0] cfg_div;
  logic [3:0]  cfg_level, dac_code;
  logic        cfg_ready, dac_strobe, sweep_start, busy;
  typedef struct {int cyc; int code; int sw;} exp_t;
  exp_t q[$];
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int m_mode = 0;
  int m_div = 0;
  int m_lvl = 0;
  dac_pattern_gen #(.BITS(4), .DIV_W(16)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_mode(cfg_mode), .cfg_div(cfg_div), .cfg_level(cfg_level), .enable(enable),
    .dac_code(dac_code), .dac_strobe(dac_strobe), .sweep_start(sweep_start), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  // Code and sweep marker of step k of a sweep, from the sweep shape alone.
  function automatic int mcode(int mode, int k, int lvl);
    int p;
    p = k % 30;
    case (mode)
      0: return k % 16;
      1: return 15 - k % 16;
      2: return p <= 15 ? p : 30 - p;
      default: return lvl;
    endcase
  endfunction
  function automatic int msw(int mode, int k);
    if (mode == 2) return (k == 0 || (k % 30 == 1 && k > 1)) ? 1 : 0;
    if (mode == 3) return k == 0 ? 1 : 0;
    return k % 16 == 0 ? 1 : 0;
  endfunction
  always @(negedge clk) begin
    exp_t e;
    if (dac_strobe) begin
      if (q.size() == 0) chk("unexpected_strobe", 1, 0);
      else begin
        e = q.pop_front();
        chk("strobe_cycle", cyc, e.cyc);
        chk("dac_code", int'(dac_code), e.code);
        chk("sweep_start", int'(sweep_start), e.sw);
      end
    end else if (sweep_start) chk("sweep_without_strobe", 1, 0);
  end
  task automatic idle_cfg(int mode, int dv, int lvl);
    @(posedge clk); #1;
    cfg_valid = 1'b1; cfg_mode = 2'(mode); cfg_div = 16'(dv); cfg_level = 4'(lvl); enable = 1'b0;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    chk("idle_ready", int'(cfg_ready), 1);
    chk("idle_code", int'(dac_code), 0);
    m_mode = mode; m_div = dv; m_lvl = lvl;
  endtask
  task automatic run(int do_cfg, int mode, int dv, int lvl, int n, int use_rst);
    int c;
    @(posedge clk); #1;
    if (do_cfg != 0) begin
      m_mode = mode; m_div = dv; m_lvl = lvl;
    end
    c = cyc + 1;
    for (int k = 0; k * (m_div + 1) < n; k++)
      q.push_back('{c + k * (m_div + 1), mcode(m_mode, k, m_lvl), msw(m_mode, k)});
    cfg_valid = do_cfg != 0; cfg_mode = 2'(mode); cfg_div = 16'(dv); cfg_level = 4'(lvl); enable = 1'b1;
    @(posedge clk); #1;
    chk("run_busy", int'(busy), 1);
    chk("run_ready", int'(cfg_ready), 0);
    for (int i = 1; i < n; i++) begin
      cfg_valid = 1'($urandom); cfg_mode = 2'($urandom); cfg_div = 16'($urandom); cfg_level = 4'($urandom);
      @(posedge clk); #1;
    end
    cfg_valid = 1'b0; enable = 1'b0;
    if (use_rst != 0) rst = 1'b1;
    @(posedge clk); #1;
    chk("stop_code", int'(dac_code), 0);
    chk("stop_busy", int'(busy), 0);
    chk("stop_ready", int'(cfg_ready), 1);
    chk("stop_strobe", int'(dac_strobe), 0);
    if (use_rst != 0) begin
      rst = 1'b0;
      m_mode = 0; m_div = 0; m_lvl = 0;
    end
  endtask
  initial begin
    rst = 1'b1; cfg_valid = 1'b0; enable = 1'b0; cfg_mode = '0; cfg_div = '0; cfg_level = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_code", int'(dac_code), 0);
    chk("reset_ready", int'(cfg_ready), 1);
    chk("reset_busy", int'(busy), 0);
    chk("reset_strobe", int'(dac_strobe), 0);
    chk("reset_sweep", int'(sweep_start), 0);
    rst = 1'b0;
    run(1, 0, 0, 0, 20, 0);
    run(1, 2, 2, 0, 3 * 32, 0);
    run(1, 1, 5, 0, 6 * 17 + 2, 0);
    run(1, 3, 3, 9, 20, 0);
    run(1, 0, 0, 0, 8, 0);
    idle_cfg(2, 1, 0);
    run(0, 0, 0, 0, 70, 0);
    run(1, 0, 1, 0, 25, 1);
    run(0, 0, 0, 0, 18, 0);
    repeat (12)
      run(int'($urandom_range(1)), int'($urandom_range(3)), int'($urandom_range(4)),
          int'($urandom_range(15)), int'($urandom_range(60, 2)), int'($urandom_range(4) == 0));
    repeat (5) @(posedge clk);
    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dac_pattern_gen.md
# dac_pattern_gen

Synthesizable stimulus source for the 4-bit resistor-ladder DAC of the RGB→YPbPr converter. It produces the per-channel code word that the DAC pins and the SPICE PWL model consume: ramp-up, ramp-down, triangle and hold sweeps, with a programmable step period. It sits directly upstream of the DAC. It also emits an update strobe and a sweep-start marker for scope triggering and bench alignment.

## Interface

**Parameters**
- `BITS`, 4: DAC code width.
- `DIV_W`, 16: step-period divider width.

**Ports**
- Clocking and reset: one clock; reset is synchronous and active-high.
  - `clk`, in, 1: single clock.
  - `rst`, in, 1: synchronous, active-high reset.
- Configuration handshake:
  - `cfg_valid`, in, 1: configuration offered.
  - `cfg_ready`, out, 1: configuration can be accepted.
  - `cfg_mode`, in, 2: 0 = RAMP_UP, 1 = RAMP_DOWN, 2 = TRIANGLE, 3 = HOLD.
  - `cfg_div`, in, DIV_W: step period minus 1, in clocks.
  - `cfg_level`, in, BITS: code output in HOLD mode.
- Control and outputs:
  - `enable`, in, 1: run request (level).
  - `dac_code`, out, BITS: registered DAC code.
  - `dac_strobe`, out, 1: one-cycle pulse in every cycle where `dac_code` takes a new step value.
  - `sweep_start`, out, 1: one-cycle pulse when a sweep begins.
  - `busy`, out, 1: FSM not in IDLE.

## Operation

**FSM states:** IDLE, UP, DOWN, HOLD.
- **IDLE**
  - `dac_code` = 0, prescaler = 0, `cfg_ready` = 1.
  - A handshake (`cfg_valid & cfg_ready`) latches mode, div and level.
  - If `enable` = 1, go to the run state of the latched mode. A config accepted in the same cycle takes effect immediately.
  - Mode → run state and start code:
    - RAMP_UP → UP, start code 0.
    - TRIANGLE → UP, start code 0.
    - RAMP_DOWN → DOWN, start code MAX = 2^BITS−1.
    - HOLD → HOLD, start code `cfg_level`.
- **Any run state**
  - `cfg_ready` = 0; `cfg_valid` is ignored.
  - `enable` = 0 → IDLE next cycle, `dac_code` = 0. This takes priority over a step.
- **Prescaler:** counts 0..div, then wraps. The wrap cycle is a step tick. div = 0 means a tick every cycle.
- **UP on tick**
  - Code < MAX: code+1.
  - Code = MAX:
    - RAMP_UP wraps to 0 and pulses `sweep_start`.
    - TRIANGLE goes to DOWN with code MAX−1. Endpoints are not repeated.
- **DOWN on tick**
  - Code > 0: code−1.
  - Code = 0:
    - RAMP_DOWN wraps to MAX and pulses `sweep_start`.
    - TRIANGLE goes to UP with code 1 and pulses `sweep_start`.
- **HOLD:** the code stays at `cfg_level`. `dac_strobe` pulses on every tick; `sweep_start` pulses only on entry.
- **Arithmetic:** unsigned, BITS wide, with explicit endpoint compares and no reliance on overflow. The prescaler is DIV_W wide and compares `==` div.

## Timing

- **Reset values:** state IDLE, `dac_code` 0, `dac_strobe` 0, `sweep_start` 0, `busy` 0, `cfg_ready` 1, prescaler 0, latched mode RAMP_UP, div 0, level 0.
- **Reset mid-sweep:** all outputs return to reset values on the next edge; the latched config is lost.
- **Entry:**
  - In the first run cycle, `dac_code` = start code, with `dac_strobe` = 1 and `sweep_start` = 1.
  - The prescaler restarts at 0 on entry.
  - The next change comes div+1 cycles later.
- **Step period:** in steady state, `dac_code` changes exactly every div+1 cycles, and `dac_strobe` is coincident with the changed value.
- **Outputs:** all registered; no combinational path from input to output except `cfg_ready` = (state == IDLE).
- **`enable` deassert:** takes effect the cycle after `enable` is sampled low. No strobe accompanies the return to 0.
- **Sweep length:**
  - Ramp sweep: 2^BITS codes.
  - Triangle period: 2·(2^BITS−1) steps.

## Structure

- Package `dac_pkg`:
  - `mode_t` enum (RAMP_UP, RAMP_DOWN, TRIANGLE, HOLD).
  - `state_t` enum (IDLE, UP, DOWN, HOLD).
  - Default `BITS`/`DIV_W` constants.
- Sub-module `dac_tick_div`:
  - Prescaler with inputs `clk`, `rst`, `clr`, `div`; output `tick`.
  - `clr` is asserted on run entry.
- FSM and code register live in the top module.

## Test plan

- **Reset/idle:** `rst` for 3 cycles → `dac_code` = 0, `cfg_ready` = 1, `busy` = 0, no strobes.
- **RAMP_UP, div = 0:** `enable` held → codes 0,1,…,15,0 on consecutive cycles. `sweep_start` at the first 0 and at the wrap; `dac_strobe` every cycle.
- **TRIANGLE, div = 2:** codes 0,1,…,15,14,…,0,1. Each value held 3 cycles. `sweep_start` at entry and at the 0→1 turn only; 15 and 0 are not repeated.
- **RAMP_DOWN, div = 5:** first code 15, then 14 after 6 cycles. Wrap 0→15 with `sweep_start`.
- **HOLD, level = 9, div = 3:** `dac_code` stays at 9. `dac_strobe` every 4 cycles; `sweep_start` once.
- **Abort and reconfig:**
  - Drop `enable` mid-RAMP_UP at code 7 → next cycle IDLE, code 0.
  - `cfg_valid` during the run is ignored.
  - A new config with `enable` in IDLE → starts with the new mode on the next cycle.
  - `rst` mid-sweep → reset values.
